// File: rtl/ecpri_tx_resp.sv
`default_nettype none
// ============================================================================
// Module   : ecpri_tx_resp
// Purpose  : Builds a complete eCPRI Remote Memory Access response frame in
//            the tx frame RAM when ecpri_rx requests one. Header fields are
//            copied from the received-frame header RAM, read-response data
//            comes from the cpri payload RAM, and short frames are zero
//            padded. The finished frame length is then reported to the MAC.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk              system clock
//   reset            synchronous, active-high reset
//   send_write_resp  start pulse: build a write response
//   send_read_resp   start pulse: build a read response (wins over write)
//   resp_payload_len RMA length field, sampled on the start pulse
//   hdr_addr/hdr_oe  header RAM read port, hdr_rdata one cycle later
//   pay_addr/pay_oe  payload RAM read port, pay_rdata one cycle later
//   tx_addr/tx_wdata/tx_we  tx frame RAM write port
//   busy             frame build in progress
//   tx_done          one-cycle pulse when the frame is complete
//   tx_len           frame length in bytes, held after tx_done
// ============================================================================
module ecpri_tx_resp #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int MIN_FRAME  = 60
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  send_write_resp,
    input  logic                  send_read_resp,
    input  logic [DATA_WIDTH-1:0] resp_payload_len,
    output logic [ADDR_WIDTH-1:0] hdr_addr,
    output logic                  hdr_oe,
    input  logic [DATA_WIDTH-1:0] hdr_rdata,
    output logic [ADDR_WIDTH-1:0] pay_addr,
    output logic                  pay_oe,
    input  logic [DATA_WIDTH-1:0] pay_rdata,
    output logic [ADDR_WIDTH-1:0] tx_addr,
    output logic [DATA_WIDTH-1:0] tx_wdata,
    output logic                  tx_we,
    output logic                  busy,
    output logic                  tx_done,
    output logic [ADDR_WIDTH-1:0] tx_len
);

    // Frame segments; the state names the segment of the byte in flight.
    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_MAC  = 3'd1;
    localparam logic [2:0] c_ST_HDR  = 3'd2;
    localparam logic [2:0] c_ST_RMA  = 3'd3;
    localparam logic [2:0] c_ST_DATA = 3'd4;
    localparam logic [2:0] c_ST_PAD  = 3'd5;
    localparam logic [2:0] c_ST_DONE = 3'd6;

    // Source of a tx byte: generated constant, header RAM or payload RAM.
    localparam logic [1:0] c_SRC_GEN = 2'd0;
    localparam logic [1:0] c_SRC_HDR = 2'd1;
    localparam logic [1:0] c_SRC_PAY = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] c_RMA_END = ADDR_WIDTH'(30);

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_pos;     // tx position of the byte in flight
    logic                  r_is_rd;
    logic [DATA_WIDTH-1:0] r_len;
    logic [1:0]            r_sel;     // what drives tx_wdata on a write cycle
    logic [DATA_WIDTH-1:0] r_wdata;   // generated byte value

    logic                  w_idle;
    logic                  w_start;
    logic                  w_is_rd;
    logic [DATA_WIDTH-1:0] w_len;
    logic [DATA_WIDTH-1:0] w_n;
    logic [15:0]           w_psize;
    logic [ADDR_WIDTH-1:0] w_data_end;
    logic [ADDR_WIDTH-1:0] w_frame_len;
    logic [ADDR_WIDTH-1:0] w_np;
    logic [2:0]            w_nstate;
    logic [1:0]            w_nkind;
    logic [ADDR_WIDTH-1:0] w_src;
    logic [DATA_WIDTH-1:0] w_gen;

    assign w_idle  = (r_state == c_ST_IDLE);
    assign w_start = send_read_resp | send_write_resp;

    // While idle the frame parameters come straight from the start inputs so
    // the first byte can be issued on the same edge that latches them.
    assign w_is_rd = w_idle ? send_read_resp : r_is_rd;
    assign w_len   = w_idle ? resp_payload_len : r_len;
    assign w_n     = w_is_rd ? w_len : '0;

    assign w_psize     = 16'd12 + 16'(w_n);
    assign w_data_end  = c_RMA_END + ADDR_WIDTH'(w_n);
    assign w_frame_len = (w_data_end < ADDR_WIDTH'(MIN_FRAME)) ?
                         ADDR_WIDTH'(MIN_FRAME) : w_data_end;

    // Position of the next byte to handle.
    assign w_np = w_idle ? '0 : r_pos + ADDR_WIDTH'(1);

    // Classify the next byte: segment, source and (if generated) its value.
    always_comb begin
        w_nstate = c_ST_DONE;
        w_nkind  = c_SRC_GEN;
        w_src    = '0;
        w_gen    = '0;
        if (w_np < ADDR_WIDTH'(12)) begin
            // Source and destination MAC swap places.
            w_nstate = c_ST_MAC;
            w_nkind  = c_SRC_HDR;
            w_src    = (w_np < ADDR_WIDTH'(6)) ? w_np + ADDR_WIDTH'(6)
                                                : w_np - ADDR_WIDTH'(6);
        end else if (w_np < ADDR_WIDTH'(18)) begin
            w_nstate = c_ST_HDR;
            case (w_np)
                ADDR_WIDTH'(12): w_gen = DATA_WIDTH'(8'hAE);
                ADDR_WIDTH'(13): w_gen = DATA_WIDTH'(8'hFE);
                ADDR_WIDTH'(14): w_gen = DATA_WIDTH'(8'h10);
                ADDR_WIDTH'(15): w_gen = DATA_WIDTH'(8'h04);
                ADDR_WIDTH'(16): w_gen = DATA_WIDTH'(w_psize[15:8]);
                default:         w_gen = DATA_WIDTH'(w_psize[7:0]);
            endcase
        end else if (w_np < c_RMA_END) begin
            w_nstate = c_ST_RMA;
            case (w_np)
                ADDR_WIDTH'(19): w_gen = w_is_rd ? DATA_WIDTH'(8'h01) : DATA_WIDTH'(8'h11);
                ADDR_WIDTH'(28): w_gen = '0;
                ADDR_WIDTH'(29): w_gen = w_len;
                default: begin
                    // RMA ID, element ID and address echo the request.
                    w_nkind = c_SRC_HDR;
                    w_src   = w_np;
                end
            endcase
        end else if (w_np < w_data_end) begin
            w_nstate = c_ST_DATA;
            w_nkind  = c_SRC_PAY;
            w_src    = w_np - c_RMA_END;
        end else if (w_np < w_frame_len) begin
            w_nstate = c_ST_PAD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_pos    <= '0;
            r_is_rd  <= 1'b0;
            r_len    <= '0;
            r_sel    <= c_SRC_GEN;
            r_wdata  <= '0;
            hdr_addr <= '0;
            hdr_oe   <= 1'b0;
            pay_addr <= '0;
            pay_oe   <= 1'b0;
            tx_addr  <= '0;
            tx_we    <= 1'b0;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
            tx_len   <= '0;
        end else begin
            hdr_oe  <= 1'b0;
            pay_oe  <= 1'b0;
            tx_we   <= 1'b0;
            tx_done <= 1'b0;

            if (w_idle && w_start) begin
                r_is_rd <= send_read_resp;
                r_len   <= resp_payload_len;
                busy    <= 1'b1;
            end

            if (r_state == c_ST_DONE) begin
                busy    <= 1'b0;
                r_state <= c_ST_IDLE;
            end else if (!w_idle && (hdr_oe || pay_oe)) begin
                // Second cycle of a copied byte: RAM data is on rdata now.
                tx_we   <= 1'b1;
                tx_addr <= r_pos;
                r_sel   <= hdr_oe ? c_SRC_HDR : c_SRC_PAY;
            end else if (!w_idle || w_start) begin
                r_pos   <= w_np;
                r_state <= w_nstate;
                if (w_nstate == c_ST_DONE) begin
                    tx_done <= 1'b1;
                    tx_len  <= w_frame_len;
                end else if (w_nkind == c_SRC_HDR) begin
                    hdr_oe   <= 1'b1;
                    hdr_addr <= w_src;
                end else if (w_nkind == c_SRC_PAY) begin
                    pay_oe   <= 1'b1;
                    pay_addr <= w_src;
                end else begin
                    tx_we   <= 1'b1;
                    tx_addr <= w_np;
                    r_wdata <= w_gen;
                    r_sel   <= c_SRC_GEN;
                end
            end
        end
    end

    // Copied bytes pass the RAM read data straight through on the write cycle.
    always_comb begin
        tx_wdata = r_wdata;
        if (r_sel == c_SRC_HDR) begin
            tx_wdata = hdr_rdata;
        end else if (r_sel == c_SRC_PAY) begin
            tx_wdata = pay_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ecpri_tx_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecpri_tx_resp
// Purpose  : Self-checking bench for ecpri_tx_resp. Models the header,
//            payload and tx RAMs, predicts every tx RAM write and frame length
//            into scoreboard queues and compares as the design produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ecpri_tx_resp;

    localparam int DW = 8;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          send_write_resp = 1'b0;
    logic          send_read_resp = 1'b0;
    logic [DW-1:0] resp_payload_len = '0;
    logic [AW-1:0] hdr_addr;
    logic          hdr_oe;
    logic [DW-1:0] hdr_rdata = '0;
    logic [AW-1:0] pay_addr;
    logic          pay_oe;
    logic [DW-1:0] pay_rdata = '0;
    logic [AW-1:0] tx_addr;
    logic [DW-1:0] tx_wdata;
    logic          tx_we;
    logic          busy;
    logic          tx_done;
    logic [AW-1:0] tx_len;

    always #5 clk = ~clk;

    ecpri_tx_resp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MIN_FRAME(60)) dut (
        .clk              (clk),
        .reset            (reset),
        .send_write_resp  (send_write_resp),
        .send_read_resp   (send_read_resp),
        .resp_payload_len (resp_payload_len),
        .hdr_addr         (hdr_addr),
        .hdr_oe           (hdr_oe),
        .hdr_rdata        (hdr_rdata),
        .pay_addr         (pay_addr),
        .pay_oe           (pay_oe),
        .pay_rdata        (pay_rdata),
        .tx_addr          (tx_addr),
        .tx_wdata         (tx_wdata),
        .tx_we            (tx_we),
        .busy             (busy),
        .tx_done          (tx_done),
        .tx_len           (tx_len)
    );

    // Source RAMs with one-cycle registered reads.
    logic [7:0] hdr_mem [0:31];
    logic [7:0] pay_mem [0:255];

    always @(posedge clk) begin
        if (hdr_oe) hdr_rdata <= hdr_mem[hdr_addr[4:0]];
        if (pay_oe) pay_rdata <= pay_mem[pay_addr[7:0]];
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int idle_viol = 0;
    int pay_oe_seen = 0;

    logic [23:0] exp_q[$];   // {tx_addr, tx_wdata}
    logic [15:0] len_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // Scoreboard consumer and output-discipline monitor.
    always @(negedge clk) begin
        if (tx_we) begin
            check("tx_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                logic [23:0] e;
                e = exp_q.pop_front();
                check("tx_byte", {8'h00, tx_addr, tx_wdata}, {8'h00, e});
            end
        end
        if (tx_done) begin
            done_cnt++;
            done_cyc = cyc;
            check("len_pending", 32'(len_q.size() > 0), 32'd1);
            if (len_q.size() > 0) begin
                logic [15:0] l;
                l = len_q.pop_front();
                check("tx_len", 32'(tx_len), 32'(l));
            end
        end
        if (!busy && (tx_we || hdr_oe || pay_oe)) idle_viol++;
        if (pay_oe) pay_oe_seen++;
    end

    task automatic push_b(input int p, input logic [7:0] d);
        exp_q.push_back({16'(p), d});
    endtask

    // Reference frame derived from the frame format.
    task automatic push_frame(input bit rd, input logic [7:0] len);
        int n;
        logic [15:0] psize;
        n = rd ? int'(len) : 0;
        psize = 16'(12 + n);
        for (int p = 0; p < 6; p++)  push_b(p, hdr_mem[p + 6]);
        for (int p = 6; p < 12; p++) push_b(p, hdr_mem[p - 6]);
        push_b(12, 8'hAE);
        push_b(13, 8'hFE);
        push_b(14, 8'h10);
        push_b(15, 8'h04);
        push_b(16, psize[15:8]);
        push_b(17, psize[7:0]);
        push_b(18, hdr_mem[18]);
        push_b(19, rd ? 8'h01 : 8'h11);
        for (int p = 20; p < 28; p++) push_b(p, hdr_mem[p]);
        push_b(28, 8'h00);
        push_b(29, len);
        for (int k = 0; k < n; k++) push_b(30 + k, pay_mem[k]);
        for (int p = 30 + n; p < 60; p++) push_b(p, 8'h00);
        len_q.push_back(16'((30 + n < 60) ? 60 : 30 + n));
    endtask

    function automatic int exp_latency(input bit rd, input int len);
        int n;
        int pad;
        n = rd ? len : 0;
        pad = (30 + n < 60) ? 60 - 30 - n : 0;
        return 1 + 2 * (21 + n) + 9 + pad;
    endfunction

    task automatic start(input bit wr, input bit rd, input logic [7:0] len);
        @(posedge clk); #1;
        push_frame(rd, len);
        send_write_resp  = wr;
        send_read_resp   = rd;
        resp_payload_len = len;
        start_cyc        = cyc;
        @(posedge clk); #1;
        send_write_resp  = 1'b0;
        send_read_resp   = 1'b0;
        resp_payload_len = 8'h55;   // must not leak into the frame
    endtask

    task automatic wait_done(input string tag, input int lat);
        int d0;
        int k;
        d0 = done_cnt;
        k = 0;
        while (done_cnt == d0 && k < 1000) begin
            @(negedge clk); #1;
            k++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
        check({tag, "_latency"}, 32'(done_cyc - start_cyc), 32'(lat));
        @(posedge clk); #1;
        check({tag, "_busy_clear"}, 32'(busy), 32'd0);
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int d;
        for (int i = 0; i < 32; i++)  hdr_mem[i] = 8'(i);
        for (int k = 0; k < 256; k++) pay_mem[k] = 8'(8'hA0 + k);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", {27'd0, busy, tx_we, hdr_oe, pay_oe, tx_done}, 32'd0);
        check("rst_raddr", {hdr_addr, pay_addr}, 32'd0);
        check("rst_tx", {8'd0, tx_addr, tx_wdata}, 32'd0);
        check("rst_len", 32'(tx_len), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // 1: write response, length field 4
        start(1'b1, 1'b0, 8'd4);
        check("t1_busy_set", 32'(busy), 32'd1);
        wait_done("t1", 82);

        // 2: read response, 40 data bytes
        start(1'b0, 1'b1, 8'd40);
        wait_done("t2", exp_latency(1'b1, 40));

        // 3: read response with no data
        pay_oe_seen = 0;
        start(1'b0, 1'b1, 8'd0);
        wait_done("t3", exp_latency(1'b1, 0));
        check("t3_no_pay_oe", 32'(pay_oe_seen), 32'd0);

        // 4: simultaneous pulses, then a write pulse while busy
        start(1'b1, 1'b1, 8'd2);
        repeat (10) @(posedge clk);
        #1 send_write_resp = 1'b1;
        @(posedge clk); #1;
        send_write_resp = 1'b0;
        wait_done("t4", exp_latency(1'b1, 2));
        d = done_cnt;
        repeat (100) @(posedge clk);
        #1 check("t4_single_frame", 32'(done_cnt), 32'(d));

        // 5: maximum read response
        start(1'b0, 1'b1, 8'd255);
        wait_done("t5", exp_latency(1'b1, 255));

        // 6: reset on cycle 20 of a build aborts it
        start(1'b1, 1'b0, 8'd4);
        repeat (19) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        check("t6_abort_busy", 32'(busy), 32'd0);
        check("t6_abort_we", 32'(tx_we), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        len_q.delete();
        d = done_cnt;
        repeat (100) @(posedge clk);
        #1 check("t6_no_done", 32'(done_cnt), 32'(d));
        start(1'b1, 1'b0, 8'd4);
        wait_done("t6_rerun", 82);

        check("idle_discipline", 32'(idle_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (checks=%0d errors=%0d)", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/ecpri_tx_resp.md
Name: ecpri_tx_resp

Overview:
Downstream neighbour of ecpri_rx. On a response request from ecpri_rx, it builds a complete eCPRI Remote Memory Access (RMA) response Ethernet frame in the tx frame RAM:
- header fields come from the received-frame header RAM;
- read-response data comes from the cpri payload RAM.
It then reports the frame length to the MAC transmit side.

Parameters:
DATA_WIDTH, 8, RAM byte width
ADDR_WIDTH, 16, RAM address width
MIN_FRAME, 60, minimum frame length in bytes (pre-FCS); shorter frames are zero-padded

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
send_write_resp  input  1  one-cycle pulse from ecpri_rx: build a write response
send_read_resp  input  1  one-cycle pulse from ecpri_rx: build a read response
resp_payload_len  input  DATA_WIDTH  RMA length field; data bytes for a read response; sampled on the start pulse
hdr_addr  output  ADDR_WIDTH  header RAM read address
hdr_oe  output  1  header RAM output enable
hdr_rdata  input  DATA_WIDTH  header RAM read data, valid the cycle after hdr_addr/hdr_oe
pay_addr  output  ADDR_WIDTH  cpri payload RAM read address
pay_oe  output  1  payload RAM output enable
pay_rdata  input  DATA_WIDTH  payload RAM read data, valid the cycle after pay_addr/pay_oe
tx_addr  output  ADDR_WIDTH  tx frame RAM write address
tx_wdata  output  DATA_WIDTH  tx frame RAM write data
tx_we  output  1  tx frame RAM write enable
busy  output  1  frame build in progress
tx_done  output  1  one-cycle pulse when the frame is complete
tx_len  output  ADDR_WIDTH  frame length in bytes, valid while tx_done=1 and held until the next start

Behaviour:
- Reset values: all addresses 0; hdr_oe, pay_oe, tx_we, busy, tx_done all 0; tx_wdata 0; tx_len 0; state IDLE.
- Reset is synchronous. Asserting reset mid-frame aborts the build: state returns to IDLE, no tx_done is issued, and partially written RAM contents are left as-is.

Header RAM layout (written by ecpri_rx, byte offsets):
- 0-5 dst MAC
- 6-11 src MAC
- 12-13 ethertype
- 14-17 eCPRI common header
- 18 RMA ID
- 19 req/resp byte
- 20-21 element ID
- 22-27 address
- 28-29 length

Start:
- In IDLE, a pulse on send_read_resp or send_write_resp latches the kind and resp_payload_len, sets busy=1 the next cycle, and moves to MAC.
- If both pulses are high in the same cycle, the read response is built and the write request is dropped.
- Pulses while busy=1 are ignored.

Copied byte (two cycles):
- Cycle A: drive the source address with oe=1.
- Cycle B: tx_we=1 with tx_wdata = rdata.

Generated byte: one cycle, tx_we=1.

tx frame byte order (tx_addr increments by 1 per written byte, starting at 0):
- MAC: tx 0-5 ← hdr 6-11; tx 6-11 ← hdr 0-5 (source and destination swapped).
- HDR: tx 12-13 = 0xAE, 0xFE; tx 14 = 0x10 (revision 1, C=0); tx 15 = 0x04 (RMA); tx 16-17 = eCPRI payload size, big-endian = 12 + N, where N = latched len for a read and 0 for a write.
- RMA:
  - tx 18 ← hdr 18.
  - tx 19 = 0x01 for a read response, 0x11 for a write response.
  - tx 20-21 ← hdr 20-21.
  - tx 22-27 ← hdr 22-27.
  - tx 28-29 = {0x00, latched len}.
- DATA (read only): tx 30+k ← payload RAM addr k, for k = 0..N-1. Skipped when N = 0 or for a write response.
- PAD: while the byte count is below MIN_FRAME, write 0x00.
- DONE: one cycle with tx_done=1 and tx_len = max(30+N, MIN_FRAME), zero-extended. Next cycle: busy=0, return to IDLE.

Write-response latency:
- Start pulse to tx_done = 1 + 21×2 + 9 + 30 (pad) = 82 cycles.
- tx_done is at cycle 82 counting the pulse cycle as 0.

Output discipline:
- oe outputs are high only in the read-issue cycles.
- tx_we is high only on write cycles.
- There are no RAM accesses in IDLE.

Width rules:
- The payload-size sum is computed in 16 bits.
- The maximum frame is 30+255 = 285 bytes and fits within ADDR_WIDTH.

Test Plan:
1. Write response: hdr RAM bytes 0-29 = 0x00..0x1D, send_write_resp, len=4 → tx 0-5=06..0B, 6-11=00..05, 12-17=AE FE 10 04 00 0C, 18=12, 19=11, 20-27=14..1B, 28-29=00 04, 30-59=00, tx_done at cycle 82, tx_len=60.
2. Read response, len=40, payload RAM k=0xA0+k → tx 16-17=00 34, 19=01, 28-29=00 28, tx 30-69=A0..C7, no pad, tx_len=70.
3. Read response len=0 → payload size 00 0C, no DATA state, pad 30-59, tx_len=60; pay_oe never asserted.
4. Both pulses in one cycle, len=2 → read response built, exactly one tx_done, tx_len=60, tx 19=01; a further send_write_resp during busy produces no second frame.
5. Read len=255 → last data byte at tx 284, tx_len=285 (0x011D), payload size 0x010B.
6. Reset asserted on cycle 20 of a build → the next cycle shows busy=0 and tx_we=0; tx_done is never pulsed; a new write response afterwards completes normally with tx_len=60.
